// File: rtl/rx_package.sv
// Shared constants, sample/tap formats and output saturation for the receive DFE.
package rx_package;

    localparam int DFE_N_TAPS     = 3;
    localparam int DFE_IN_WIDTH   = 16;
    localparam int DFE_TAP_WIDTH  = 12;
    localparam int DFE_ADDR_WIDTH = 2;
    localparam int DFE_ACC_WIDTH  = DFE_IN_WIDTH + 2;

    typedef logic signed [DFE_IN_WIDTH-1:0]  DFE_SAMPLE_FORMAT;
    typedef logic signed [DFE_TAP_WIDTH-1:0] DFE_TAP_FORMAT;

    // Overflow is visible as disagreement among the top guard bits and the sample sign bit.
    function automatic DFE_SAMPLE_FORMAT saturate(input logic signed [DFE_ACC_WIDTH-1:0] v);
        if (v[DFE_ACC_WIDTH-1] && !(&v[DFE_ACC_WIDTH-2:DFE_IN_WIDTH-1]))
            return {1'b1, {(DFE_IN_WIDTH-1){1'b0}}};
        else if (!v[DFE_ACC_WIDTH-1] && (|v[DFE_ACC_WIDTH-2:DFE_IN_WIDTH-1]))
            return {1'b0, {(DFE_IN_WIDTH-1){1'b1}}};
        else
            return v[DFE_IN_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/dfe_tap_bank.sv
// Shadow/active tap weight bank: writes land in shadow, commit copies shadow to active atomically.
module dfe_tap_bank
    import rx_package::*;
#(
    parameter int N_TAPS     = DFE_N_TAPS,
    parameter int TAP_WIDTH  = DFE_TAP_WIDTH,
    parameter int ADDR_WIDTH = DFE_ADDR_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr_en,
    input  logic [ADDR_WIDTH-1:0]       i_wr_addr,
    input  logic signed [TAP_WIDTH-1:0] i_wr_data,
    input  logic                        i_commit,
    output logic signed [TAP_WIDTH-1:0] o_taps [N_TAPS],
    output logic [TAP_WIDTH-1:0]        o_ref
);

    // Slots 0..N_TAPS-1 hold h1..hN, slot N_TAPS holds the slicer reference level.
    logic signed [TAP_WIDTH-1:0] r_shadow [N_TAPS+1];
    logic signed [TAP_WIDTH-1:0] r_active [N_TAPS+1];
    logic signed [TAP_WIDTH-1:0] w_wr_val;

    // The reference level is a magnitude, so negative writes to its slot clamp to zero.
    assign w_wr_val = (int'(i_wr_addr) == N_TAPS && i_wr_data[TAP_WIDTH-1]) ? '0 : i_wr_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i <= N_TAPS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (i_commit)
                r_active <= r_shadow;
            for (int i = 0; i <= N_TAPS; i++) begin
                if (i_wr_en && int'(i_wr_addr) == i)
                    r_shadow[i] <= w_wr_val;
            end
        end
    end

    for (genvar k = 0; k < N_TAPS; k++) begin : g_taps
        assign o_taps[k] = r_active[k];
    end
    assign o_ref = r_active[N_TAPS];

endmodule

// File: rtl/rx_dfe.sv
// Decision-feedback equalizer: cancels post-cursor ISI using past decisions, slices to a bit,
// and reports the equalized value and slicer error one cycle after each valid sample.
module rx_dfe
    import rx_package::*;
#(
    parameter int N_DFE_TAPS = DFE_N_TAPS,
    parameter int IN_WIDTH   = DFE_IN_WIDTH,
    parameter int TAP_WIDTH  = DFE_TAP_WIDTH,
    parameter int ADDR_WIDTH = DFE_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  in_sample,
    input  logic                        in_valid,
    input  logic                        tap_wr_en,
    input  logic [ADDR_WIDTH-1:0]       tap_wr_addr,
    input  logic signed [TAP_WIDTH-1:0] tap_wr_data,
    input  logic                        tap_commit,
    output logic                        out_bit,
    output logic                        out_valid,
    output logic signed [IN_WIDTH-1:0]  out_eq,
    output logic signed [IN_WIDTH-1:0]  out_err
);

    localparam int ACC_WIDTH = IN_WIDTH + 2;

    // The shared saturate function is fixed to the package formats.
    if (IN_WIDTH != DFE_IN_WIDTH || TAP_WIDTH > ACC_WIDTH || (2**ADDR_WIDTH) < N_DFE_TAPS + 1) begin : g_bad_params
        $error("rx_dfe: unsupported parameter set");
    end

    logic signed [TAP_WIDTH-1:0] w_taps [N_DFE_TAPS];
    logic [TAP_WIDTH-1:0]        w_ref;
    logic [ACC_WIDTH-1:0]        w_ref_ext;
    logic signed [ACC_WIDTH-1:0] w_acc;
    logic signed [ACC_WIDTH-1:0] w_err_acc;
    DFE_SAMPLE_FORMAT            w_eq;
    DFE_SAMPLE_FORMAT            w_err;
    logic                        w_bit;
    logic [N_DFE_TAPS-1:0]       r_hist;

    dfe_tap_bank #(
        .N_TAPS    (N_DFE_TAPS),
        .TAP_WIDTH (TAP_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_tap_bank (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_wr_en  (tap_wr_en),
        .i_wr_addr(tap_wr_addr),
        .i_wr_data(tap_wr_data),
        .i_commit (tap_commit),
        .o_taps   (w_taps),
        .o_ref    (w_ref)
    );

    // r_hist[k] holds d[n-1-k]; a 1 feeds +h, a 0 feeds -h, so subtracting h*s becomes add/sub.
    always_comb begin
        w_acc = {{(ACC_WIDTH-IN_WIDTH){in_sample[IN_WIDTH-1]}}, in_sample};
        for (int k = 0; k < N_DFE_TAPS; k++) begin
            if (r_hist[k])
                w_acc = w_acc - {{(ACC_WIDTH-TAP_WIDTH){w_taps[k][TAP_WIDTH-1]}}, w_taps[k]};
            else
                w_acc = w_acc + {{(ACC_WIDTH-TAP_WIDTH){w_taps[k][TAP_WIDTH-1]}}, w_taps[k]};
        end
        w_eq      = saturate(w_acc);
        w_bit     = ~w_eq[IN_WIDTH-1];
        w_ref_ext = {{(ACC_WIDTH-TAP_WIDTH){1'b0}}, w_ref};
        w_err_acc = {{(ACC_WIDTH-IN_WIDTH){w_eq[IN_WIDTH-1]}}, w_eq}
                    - (w_bit ? w_ref_ext : -w_ref_ext);
        w_err     = saturate(w_err_acc);
    end

    // The decision feeds straight back into r_hist so the next sample sees it without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist    <= '0;
            out_bit   <= 1'b0;
            out_eq    <= '0;
            out_err   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_bit <= w_bit;
                out_eq  <= w_eq;
                out_err <= w_err;
                r_hist  <= (r_hist << 1) | N_DFE_TAPS'(w_bit);
            end
        end
    end

endmodule

// File: tb/tb_rx_dfe.sv
// Directed bench for rx_dfe: an arithmetic reference model checked every cycle, plus literal spot checks.
module tb_rx_dfe;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] in_sample;
    logic               in_valid;
    logic               tap_wr_en;
    logic [1:0]         tap_wr_addr;
    logic signed [11:0] tap_wr_data;
    logic               tap_commit;
    logic               out_bit;
    logic               out_valid;
    logic signed [15:0] out_eq;
    logic signed [15:0] out_err;

    int n_checks = 0;
    int n_fail   = 0;

    rx_dfe dut (
        .clk        (clk),
        .rst        (rst),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .tap_wr_en  (tap_wr_en),
        .tap_wr_addr(tap_wr_addr),
        .tap_wr_data(tap_wr_data),
        .tap_commit (tap_commit),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .out_eq     (out_eq),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    // Reference model: weights h[0..2] = h1..h3, h[3] = ref; hist[k] = d[n-k].
    int m_shadow [0:3];
    int m_active [0:3];
    bit m_hist   [1:3];
    bit m_valid;
    bit m_bit;
    int m_eq;
    int m_err;

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int model_eq(input int s);
        int acc = s;
        for (int k = 1; k <= 3; k++)
            acc = acc - m_active[k-1] * (m_hist[k] ? 1 : -1);
        return clamp16(acc);
    endfunction

    function automatic int model_err(input int eq);
        return clamp16(eq >= 0 ? eq - m_active[3] : eq + m_active[3]);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_bit   <= 1'b0;
            m_eq    <= 0;
            m_err   <= 0;
            for (int k = 0; k < 4; k++) begin
                m_shadow[k] <= 0;
                m_active[k] <= 0;
            end
            for (int k = 1; k <= 3; k++)
                m_hist[k] <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                m_eq      <= model_eq(int'(in_sample));
                m_bit     <= (model_eq(int'(in_sample)) >= 0);
                m_err     <= model_err(model_eq(int'(in_sample)));
                m_hist[1] <= (model_eq(int'(in_sample)) >= 0);
                m_hist[2] <= m_hist[1];
                m_hist[3] <= m_hist[2];
            end
            if (tap_commit)
                for (int k = 0; k < 4; k++)
                    m_active[k] <= m_shadow[k];
            if (tap_wr_en)
                m_shadow[tap_wr_addr] <= (tap_wr_addr == 2'd3 && tap_wr_data < 0) ? 0 : int'(tap_wr_data);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs only move on posedge or async reset; negedge sampling is away from both.
    always @(negedge clk) begin
        check("model_valid", int'(out_valid), int'(m_valid));
        check("model_bit",   int'(out_bit),   int'(m_bit));
        check("model_eq",    int'(out_eq),    m_eq);
        check("model_err",   int'(out_err),   m_err);
    end

    task automatic expect_out(input string name, input int v, input int b, input int eq, input int err);
        check({name, "_valid"}, int'(out_valid), v);
        check({name, "_bit"},   int'(out_bit),   b);
        check({name, "_eq"},    int'(out_eq),    eq);
        check({name, "_err"},   int'(out_err),   err);
    endtask

    // Called at a negedge; applies inputs for one posedge and returns at the following negedge.
    task automatic drive(input bit v, input int s, input bit we, input int a, input int d, input bit c);
        in_valid    = v;
        in_sample   = 16'(s);
        tap_wr_en   = we;
        tap_wr_addr = 2'(a);
        tap_wr_data = 12'(d);
        tap_commit  = c;
        @(negedge clk);
        in_valid    = 1'b0;
        in_sample   = '0;
        tap_wr_en   = 1'b0;
        tap_wr_addr = '0;
        tap_wr_data = '0;
        tap_commit  = 1'b0;
    endtask

    task automatic samp(input int s);        drive(1'b1, s, 1'b0, 0, 0, 1'b0); endtask
    task automatic wr(input int a, input int d); drive(1'b0, 0, 1'b1, a, d, 1'b0); endtask
    task automatic commit();                 drive(1'b0, 0, 1'b0, 0, 0, 1'b1); endtask
    task automatic idle();                   drive(1'b0, 0, 1'b0, 0, 0, 1'b0); endtask

    // Pulses reset low between clock edges and checks the outputs clear without a clock.
    task automatic do_reset(input string name);
        #2 rst = 1'b0;
        #1 expect_out(name, 0, 0, 0, 0);
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_sample = '0; tap_wr_en = 1'b0;
        tap_wr_addr = '0; tap_wr_data = '0; tap_commit = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        expect_out("reset", 0, 0, 0, 0);
        rst = 1'b1;

        // Zero taps: eq follows the sample, zero slices to 1.
        samp(5);   expect_out("t1_p5", 1, 1, 5, 5);
        samp(-5);  expect_out("t1_m5", 1, 0, -5, -5);
        samp(0);   expect_out("t1_z",  1, 1, 0, 0);
        idle();    check("t1_valid_drop", int'(out_valid), 0);

        // h1=100: cleared history feeds -1, then the fresh 1 decision feeds +1.
        do_reset("t2_rst");
        wr(0, 100); commit();
        samp(-50); expect_out("t2_first",  1, 1, 50, 50);
        samp(-50); expect_out("t2_second", 1, 0, -150, -150);

        // Saturation with h1..h3 = -2048.
        do_reset("t3_rst");
        wr(0, -2048); wr(1, -2048); wr(2, -2048); commit();
        samp(32767); expect_out("t3_a", 1, 1, 26623, 26623);
        samp(32767); expect_out("t3_b", 1, 1, 30719, 30719);
        samp(32767); expect_out("t3_c", 1, 1, 32767, 32767);
        samp(1000);  expect_out("t3_d", 1, 1, 7144, 7144);
        samp(32767); expect_out("t3_e", 1, 1, 32767, 32767);
        wr(0, 2047); wr(1, 2047); wr(2, 2047); commit();
        samp(-32768); expect_out("t3_neg", 1, 0, -32768, -32768);

        // Reference level and slicer error.
        do_reset("t4_rst");
        wr(3, 1000); commit();
        samp(300);    expect_out("t4_p300", 1, 1, 300, -700);
        samp(-300);   expect_out("t4_m300", 1, 0, -300, 700);
        samp(-32768); expect_out("t4_min",  1, 0, -32768, -31768);
        wr(3, -5); commit();
        samp(300);    expect_out("t4_negref", 1, 1, 300, 300);

        // Shadow vs active timing.
        do_reset("t5_rst");
        wr(0, 200);
        samp(-50); expect_out("t5_uncommitted", 1, 0, -50, -50);
        drive(1'b0, 0, 1'b1, 0, 300, 1'b1);
        samp(-50); expect_out("t5_wr_commit", 1, 1, 150, 150);
        commit();
        samp(-50); expect_out("t5_second_commit", 1, 0, -350, -350);
        wr(0, 0);
        drive(1'b1, -50, 1'b0, 0, 0, 1'b1);
        expect_out("t5_sample_on_commit", 1, 1, 250, 250);
        samp(-50); expect_out("t5_after", 1, 0, -50, -50);
        commit(); commit();
        samp(-50); expect_out("t5_repeat_commit", 1, 0, -50, -50);

        // Valid gaps hold history and outputs; mid-stream reset clears history.
        do_reset("t6_rst");
        wr(0, 100); commit();
        samp(-50); expect_out("t6_v1", 1, 1, 50, 50);
        idle();    expect_out("t6_gap1", 0, 1, 50, 50);
        idle();    expect_out("t6_gap2", 0, 1, 50, 50);
        samp(-50); expect_out("t6_v2", 1, 0, -150, -150);
        samp(500); expect_out("t6_v3", 1, 1, 600, 600);
        do_reset("t6_midrst");
        wr(0, 100); commit();
        samp(-50); expect_out("t6_post_rst", 1, 1, 50, 50);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
